// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB first, one full adder per cycle.
// A start sampled in IDLE or DONE captures the operands; WIDTH bit-steps later
// the result is registered and done pulses for one cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request; accepted only in IDLE or DONE
//   a, b           WIDTH-bit operands, captured on accept
//   sub, cin       0: a+b+cin, 1: a-b-cin (cin is borrow-in); captured on accept
//   busy           high while bit-steps are running
//   done           one-cycle pulse, result valid
//   sum/cout/ovf   result, carry-out (sub: 1 = no borrow), signed overflow
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Full adder built from two half adders and an OR gate.
  logic ha0_s_c, ha0_c_c, ha1_s_c, ha1_c_c, fa_co_c;
  assign ha0_s_c = a_sh_q[0] ^ b_sh_q[0];
  assign ha0_c_c = a_sh_q[0] & b_sh_q[0];
  assign ha1_s_c = ha0_s_c ^ carry_q;
  assign ha1_c_c = ha0_s_c & carry_q;
  assign fa_co_c = ha0_c_c | ha1_c_c;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          // Subtraction is a + ~b + !borrow_in.
          b_sh_d  = sub ? ~b : b;
          s_sh_d  = '0;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {ha1_s_c, s_sh_q[WIDTH-1:1]};
        carry_d = fa_co_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          // carry_q is still the carry into the MSB on this step.
          state_d = DONE;
          sum_d   = {ha1_s_c, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_co_c;
          ovf_d   = carry_q ^ fa_co_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks of serial_addsub at WIDTH=8 plus an
// exhaustive sweep of a WIDTH=4 instance against an integer model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .sub(sub4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One WIDTH=8 operation from IDLE/DONE; poke>0 pulses start (with other
  // operands) that many cycles into RUN.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic ts, input logic tc, input logic [7:0] es,
                       input logic ec, input logic eo, input int poke);
    logic [7:0] prev;
    int lat;
    prev  = sum;
    start = 1'b1; a = ta; b = tb_; sub = ts; cin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb_; sub = ~ts; cin = ~tc;
    lat = 0;
    while (lat < 20) begin
      if (done === 1'b1) break;
      check({tag, " busy"}, 32'(busy), 32'(1));
      check({tag, " hold"}, 32'(sum), 32'(prev));
      start = (poke > 0) && (lat == poke);
      if (start) a = 8'h11;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(8));
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    check({tag, " busy_end"}, 32'(busy), 32'(0));
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(done), 32'(0));
    check({tag, " keep"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int lat;
    int r, sr, sx, sy;
    logic [3:0] esum;
    logic ecout, eovf;

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; cin4 = 1'b0;
    #3;
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst sum", 32'(sum), 32'(0));
    check("rst cout", 32'(cout), 32'(0));
    check("rst ovf", 32'(ovf), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add 3C+0F", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 0);

    // Asynchronous reset mid-cycle clears held results immediately.
    #2 rst_n = 1'b0;
    #1;
    check("async sum", 32'(sum), 32'(0));
    check("async cout", 32'(cout), 32'(0));
    check("async busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    do_op("add 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    do_op("add 0+0+1", 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 0);
    do_op("sub 05-07", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 0);
    do_op("sub 80-01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 0);
    do_op("sub 10-0-1", 8'h10, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 0);
    do_op("poke in RUN", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 3);

    // Back-to-back: start held in the DONE cycle.
    start = 1'b1; a = 8'h01; b = 8'h02; sub = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b first lat", 32'(lat), 32'(8));
    check("b2b first sum", 32'(sum), 32'(8'h03));
    start = 1'b1; a = 8'h20; b = 8'h05; sub = 1'b1; cin = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
    end while (done !== 1'b1 && lat < 20);
    check("b2b gap", 32'(lat), 32'(9));
    check("b2b sum", 32'(sum), 32'(8'h1B));
    check("b2b cout", 32'(cout), 32'(1));
    check("b2b ovf", 32'(ovf), 32'(0));
    @(posedge clk); #1;

    // Abort after four bit-steps; a nonzero result is held beforehand.
    do_op("pre-abort", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    start = 1'b1; a = 8'h3C; b = 8'h0F; sub = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort sum", 32'(sum), 32'(0));
    check("abort cout", 32'(cout), 32'(0));
    check("abort ovf", 32'(ovf), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("abort no done", 32'(done), 32'(0));
    end
    do_op("after abort", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 0);

    // Exhaustive WIDTH=4 sweep against integer arithmetic.
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            start4 = 1'b1; a4 = 4'(x); b4 = 4'(y); sub4 = 1'(s); cin4 = 1'(c);
            @(posedge clk); #1;
            start4 = 1'b0;
            lat = 0;
            while (done4 !== 1'b1 && lat < 10) begin
              @(posedge clk); #1;
              lat++;
            end
            sx = (x > 7) ? x - 16 : x;
            sy = (y > 7) ? y - 16 : y;
            if (s == 0) begin
              r     = x + y + c;
              sr    = sx + sy + c;
              ecout = (r > 15);
            end else begin
              r     = x - y - c;
              sr    = sx - sy - c;
              ecout = (r >= 0);
            end
            esum = 4'(r & 15);
            eovf = (sr > 7) || (sr < -8);
            check($sformatf("w4 s%0d c%0d %0h,%0h lat", s, c, x, y), 32'(lat), 32'(4));
            check($sformatf("w4 s%0d c%0d %0h,%0h sum", s, c, x, y), 32'(sum4), 32'(esum));
            check($sformatf("w4 s%0d c%0d %0h,%0h cout", s, c, x, y), 32'(cout4), 32'(ecout));
            check($sformatf("w4 s%0d c%0d %0h,%0h ovf", s, c, x, y), 32'(ovf4), 32'(eovf));
          end
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
